// File: rtl/frame_stream_pkg.sv
// Shared types and default sizing for the RIFFA frame stream control unit.
// Holds the one-hot state encoding and the default parameter constants.
package frame_stream_pkg;

  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_FIFO_DEPTH   = 512;
  localparam int DEF_PROC_LATENCY = 8;

  typedef enum int unsigned {
    IDLE_B   = 0,
    ACK_B    = 1,
    STREAM_B = 2,
    DRAIN_B  = 3,
    PAD_B    = 4
  } state_bit_e;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    ACK    = 5'b00010,
    STREAM = 5'b00100,
    DRAIN  = 5'b01000,
    PAD    = 5'b10000
  } state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head visible combinationally, write-to-read latency 1 cycle.
// Push while full is dropped (wr_drop) unless a pop happens the same cycle; pop while empty is ignored.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   usedw,
  output logic                          wr_drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t FULL = cnt_t'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t cnt_q, cnt_d;
  logic rd_ok, wr_ok;

  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign rd_ok   = rd_en && !clr && (cnt_q != '0);
  assign wr_ok   = wr_en && !clr && ((cnt_q != FULL) || rd_ok);
  assign wr_drop = wr_en && !clr && (cnt_q == FULL) && !rd_ok;
  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (cnt_q == '0);
  assign usedw   = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (wr_ok && !rd_ok)      cnt_d = cnt_q + cnt_t'(1);
      else if (!wr_ok && rd_ok) cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/control_unit_frame_stream.sv
// RIFFA rx->(kernel|bypass)->FIFO->tx frame controller; rx beat reaches the FIFO 1 cycle later in bypass.
// rx_ren throttles on FIFO fill with a kernel-latency margin; tx waits on tx_data_ren; short frames are zero-padded.
module control_unit_frame_stream
  import frame_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int PROC_LATENCY = DEF_PROC_LATENCY
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_bypass,
  input  logic                  i_channel_rx,
  input  logic                  i_channel_rx_last,
  input  logic [31:0]           i_channel_rx_length,
  input  logic [30:0]           i_channel_rx_offset,
  input  logic [DATA_WIDTH-1:0] i_channel_rx_data,
  input  logic                  i_channel_rx_data_valid,
  output logic                  o_channel_rx_clk,
  output logic                  o_channel_rx_ack,
  output logic                  o_channel_rx_data_ren,
  input  logic                  i_channel_tx_ack,
  input  logic                  i_channel_tx_data_ren,
  output logic                  o_channel_tx_clk,
  output logic                  o_channel_tx,
  output logic                  o_channel_tx_last,
  output logic [31:0]           o_channel_tx_length,
  output logic [30:0]           o_channel_tx_offset,
  output logic [DATA_WIDTH-1:0] o_channel_tx_data,
  output logic                  o_channel_tx_data_valid,
  output logic [DATA_WIDTH-1:0] o_proc_data,
  output logic                  o_proc_valid,
  input  logic [DATA_WIDTH-1:0] i_proc_data,
  input  logic                  i_proc_valid,
  output logic [15:0]           o_frame_count,
  output logic                  o_overflow,
  output logic                  o_truncated,
  output logic                  o_busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WPB = DATA_WIDTH / 32;
  typedef logic [AW:0] cnt_t;
  localparam cnt_t REN_LIMIT = cnt_t'(FIFO_DEPTH - PROC_LATENCY - 2);

  state_e                state_q, state_d;
  logic [31:0]           len_q, len_d, beats_q, beats_d;
  logic [31:0]           rx_beats_q, rx_beats_d, tx_beats_q, tx_beats_d;
  logic                  bypass_q, bypass_d, stage_vld_q, stage_vld_d;
  logic [DATA_WIDTH-1:0] stage_dat_q, stage_dat_d;
  logic [15:0]           pend_q, pend_d, frame_cnt_q, frame_cnt_d;
  logic                  ovf_q, ovf_d, trunc_q, trunc_d;

  logic st_ack, st_stream, st_drain, st_pad, tx_active;
  logic rx_ren, rx_fire, tx_vld, tx_fire, proc_issue, proc_ret, kern_pending;
  logic fifo_clr, fifo_wr, fifo_rd, fifo_empty, fifo_drop;
  logic [DATA_WIDTH-1:0] fifo_wr_dat, fifo_head;
  cnt_t fifo_usedw;
  logic [32:0] rx_words_rnd;
  logic unused_inputs;

  assign unused_inputs = ^{i_channel_rx_last, i_channel_rx_offset, i_channel_tx_ack};

  assign st_ack    = state_q[ACK_B];
  assign st_stream = state_q[STREAM_B];
  assign st_drain  = state_q[DRAIN_B];
  assign st_pad    = state_q[PAD_B];
  assign tx_active = st_stream | st_drain | st_pad;

  assign rx_words_rnd = {1'b0, i_channel_rx_length} + 33'(WPB - 1);
  assign rx_ren  = st_stream && (rx_beats_q < beats_q) && (fifo_usedw < REN_LIMIT);
  assign rx_fire = rx_ren && i_channel_rx_data_valid;

  assign proc_issue   = stage_vld_q && !bypass_q;
  assign proc_ret     = i_proc_valid && (pend_q != '0);
  assign kern_pending = stage_vld_q || (pend_q != '0);

  // Late kernel beats (after the last tx beat, or outside the frame) are dropped here.
  assign fifo_wr     = (st_stream | st_drain) && (tx_beats_q < beats_q) &&
                       (bypass_q ? stage_vld_q : i_proc_valid);
  assign fifo_wr_dat = bypass_q ? stage_dat_q : i_proc_data;

  assign tx_vld  = ((st_stream | st_drain) && !fifo_empty) || st_pad;
  assign tx_fire = tx_vld && i_channel_tx_data_ren;
  assign fifo_rd = tx_fire && !st_pad;

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (i_reset_n),
    .clr     (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wr_dat),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .usedw   (fifo_usedw),
    .wr_drop (fifo_drop)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    bypass_d    = bypass_q;
    beats_d     = beats_q;
    rx_beats_d  = rx_beats_q + (rx_fire ? 32'd1 : 32'd0);
    tx_beats_d  = tx_beats_q + (tx_fire ? 32'd1 : 32'd0);
    stage_vld_d = rx_fire;
    stage_dat_d = rx_fire ? i_channel_rx_data : stage_dat_q;
    pend_d      = pend_q;
    if (proc_issue && !proc_ret)      pend_d = pend_q + 16'd1;
    else if (!proc_issue && proc_ret) pend_d = pend_q - 16'd1;
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q | fifo_drop;
    trunc_d     = trunc_q;
    fifo_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_channel_rx) begin
          state_d    = ACK;
          len_d      = i_channel_rx_length;
          bypass_d   = i_bypass;
          beats_d    = 32'(rx_words_rnd / 33'(WPB));
          rx_beats_d = '0;
          tx_beats_d = '0;
          pend_d     = '0;
          fifo_clr   = 1'b1;
        end
      end
      ACK: begin
        if (len_q == '0) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (rx_beats_q == beats_q) begin
          state_d = DRAIN;
        end else if (!i_channel_rx && !rx_fire && fifo_empty && !kern_pending) begin
          // Host gave up early: everything received is already out, pad the rest.
          state_d = PAD;
          trunc_d = 1'b1;
        end
      end
      DRAIN, PAD: begin
        if (tx_fire && (tx_beats_d == beats_q)) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      bypass_q    <= 1'b0;
      beats_q     <= '0;
      rx_beats_q  <= '0;
      tx_beats_q  <= '0;
      stage_vld_q <= 1'b0;
      stage_dat_q <= '0;
      pend_q      <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bypass_q    <= bypass_d;
      beats_q     <= beats_d;
      rx_beats_q  <= rx_beats_d;
      tx_beats_q  <= tx_beats_d;
      stage_vld_q <= stage_vld_d;
      stage_dat_q <= stage_dat_d;
      pend_q      <= pend_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      trunc_q     <= trunc_d;
    end
  end

  assign o_channel_rx_clk        = clk;
  assign o_channel_tx_clk        = clk;
  assign o_channel_rx_ack        = st_ack;
  assign o_channel_rx_data_ren   = rx_ren;
  assign o_channel_tx            = tx_active;
  assign o_channel_tx_last       = tx_active;
  assign o_channel_tx_length     = len_q;
  assign o_channel_tx_offset     = '0;
  assign o_channel_tx_data       = (st_stream | st_drain) ? fifo_head : '0;
  assign o_channel_tx_data_valid = tx_vld;
  assign o_proc_valid            = proc_issue;
  assign o_proc_data             = stage_dat_q;
  assign o_frame_count           = frame_cnt_q;
  assign o_overflow              = ovf_q;
  assign o_truncated             = trunc_q;
  assign o_busy                  = !state_q[IDLE_B];

endmodule

// File: tb/tb_control_unit_frame_stream.sv
// Scoreboard bench for control_unit_frame_stream: directed frames push expected tx beats,
// an independent monitor pops and compares every accepted tx beat.
module tb_control_unit_frame_stream;

  localparam int DW    = 64;
  localparam int DEPTH = 64;
  localparam int LAT   = 8;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic          i_reset_n, i_bypass, i_channel_rx, i_channel_rx_last, i_channel_rx_data_valid;
  logic [31:0]   i_channel_rx_length;
  logic [30:0]   i_channel_rx_offset;
  logic [DW-1:0] i_channel_rx_data, i_proc_data, o_proc_data, o_channel_tx_data;
  logic          i_channel_tx_ack, i_channel_tx_data_ren, i_proc_valid;
  logic          o_channel_rx_clk, o_channel_rx_ack, o_channel_rx_data_ren, o_channel_tx_clk;
  logic          o_channel_tx, o_channel_tx_last, o_channel_tx_data_valid, o_proc_valid;
  logic [31:0]   o_channel_tx_length;
  logic [30:0]   o_channel_tx_offset;
  logic [15:0]   o_frame_count;
  logic          o_overflow, o_truncated, o_busy;

  control_unit_frame_stream #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PROC_LATENCY(LAT)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_bypass(i_bypass),
    .i_channel_rx(i_channel_rx), .i_channel_rx_last(i_channel_rx_last),
    .i_channel_rx_length(i_channel_rx_length), .i_channel_rx_offset(i_channel_rx_offset),
    .i_channel_rx_data(i_channel_rx_data), .i_channel_rx_data_valid(i_channel_rx_data_valid),
    .o_channel_rx_clk(o_channel_rx_clk), .o_channel_rx_ack(o_channel_rx_ack),
    .o_channel_rx_data_ren(o_channel_rx_data_ren),
    .i_channel_tx_ack(i_channel_tx_ack), .i_channel_tx_data_ren(i_channel_tx_data_ren),
    .o_channel_tx_clk(o_channel_tx_clk), .o_channel_tx(o_channel_tx),
    .o_channel_tx_last(o_channel_tx_last), .o_channel_tx_length(o_channel_tx_length),
    .o_channel_tx_offset(o_channel_tx_offset), .o_channel_tx_data(o_channel_tx_data),
    .o_channel_tx_data_valid(o_channel_tx_data_valid),
    .o_proc_data(o_proc_data), .o_proc_valid(o_proc_valid),
    .i_proc_data(i_proc_data), .i_proc_valid(i_proc_valid),
    .o_frame_count(o_frame_count), .o_overflow(o_overflow),
    .o_truncated(o_truncated), .o_busy(o_busy)
  );

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];
  int pops = 0;
  int tx_hi = 0;
  logic [31:0] exp_len = '0;
  int exp_frames = 0;
  int hold = 0;
  bit toggle = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [DW-1:0] seed, input int i);
    return seed + 64'(i) * 64'h0001_0003_0005_0007;
  endfunction

  // Monitor: every accepted tx beat is compared against the scoreboard head.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (o_channel_tx) tx_hi++;
      if (o_channel_tx_data_valid && i_channel_tx_data_ren) begin
        pops++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tx_beat: got %0h, expected no beat", o_channel_tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", o_channel_tx_data, e);
          check("tx_length", 64'(o_channel_tx_length), 64'(exp_len));
          check("tx_hdr", 64'({o_channel_tx, o_channel_tx_last, o_channel_tx_offset}), 64'({2'b11, 31'd0}));
        end
      end
    end
  end

  // Host tx side: optional hold-off, optional alternating ready.
  initial begin
    i_channel_tx_data_ren = 1'b0;
    forever begin
      @(negedge clk);
      if (hold > 0) begin
        i_channel_tx_data_ren = 1'b0;
        hold--;
      end else if (toggle) begin
        i_channel_tx_data_ren = !i_channel_tx_data_ren;
      end else begin
        i_channel_tx_data_ren = 1'b1;
      end
    end
  end

  // Kernel model: inverts data, o_proc_valid to i_proc_valid is 8 cycles.
  initial begin
    logic          pv [9];
    logic [DW-1:0] pd [9];
    for (int k = 0; k < 9; k++) begin pv[k] = 1'b0; pd[k] = '0; end
    i_proc_valid = 1'b0;
    i_proc_data  = '0;
    forever begin
      @(negedge clk);
      for (int k = 8; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; end
      pv[0] = o_proc_valid;
      pd[0] = ~o_proc_data;
      if (!i_reset_n) for (int k = 0; k < 9; k++) pv[k] = 1'b0;
      i_proc_valid = pv[8];
      i_proc_data  = pd[8];
    end
  end

  task automatic wait_idle(input int bound);
    int g = 0;
    @(negedge clk);
    #1;
    while (o_busy && g < bound) begin
      g++;
      @(negedge clk);
      #1;
    end
    check("idle_within_bound", 64'(o_busy), 64'(0));
  endtask

  // mode 0: full frame, 1: drop rx after nsend beats, 2: stop after nsend beats (rx left high)
  task automatic send_frame(input int len, input bit byp, input int nsend, input int mode,
                            input logic [DW-1:0] seed, output int stalls);
    int nb;
    int guard;
    bit seen;
    int p0;
    int h0;
    logic [DW-1:0] d;
    nb = (len + 1) / 2;
    p0 = pops;
    h0 = tx_hi;
    stalls = 0;
    exp_len = 32'(len);
    @(negedge clk);
    i_bypass = byp;
    i_channel_rx_length = 32'(len);
    i_channel_rx = 1'b1;
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < 20) begin
      #1;
      seen = o_channel_rx_ack;
      if (!seen) begin
        guard++;
        @(negedge clk);
      end
    end
    check("rx_ack_seen", 64'(seen), 64'(1));
    @(negedge clk);
    if (len == 0) i_channel_rx = 1'b0;
    #1;
    check("rx_ack_one_cycle", 64'(o_channel_rx_ack), 64'(0));
    for (int i = 0; i < nsend; i++) begin
      if (i > 0) @(negedge clk);
      d = pat(seed, i);
      i_channel_rx_data = d;
      i_channel_rx_data_valid = 1'b1;
      exp_q.push_back(byp ? d : ~d);
      guard = 0;
      #1;
      while (!o_channel_rx_data_ren && guard < 3000) begin
        stalls++;
        guard++;
        @(negedge clk);
        #1;
      end
      if (!o_channel_rx_data_ren) begin
        check("rx_ren_within_bound", 64'(o_channel_rx_data_ren), 64'(1));
        break;
      end
    end
    @(negedge clk);
    i_channel_rx_data_valid = 1'b0;
    if (mode == 2) return;
    i_channel_rx = 1'b0;
    if (mode == 1) for (int i = nsend; i < nb; i++) exp_q.push_back('0);
    exp_frames++;
    wait_idle(5000);
    check("frame_count", 64'(o_frame_count), 64'(exp_frames));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("tx_beat_count", 64'(pops - p0), 64'(nb));
    if (len == 0) check("no_tx_for_empty_frame", 64'(tx_hi - h0), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    i_reset_n = 1'b0;
    i_bypass = 1'b0;
    i_channel_rx = 1'b0;
    i_channel_rx_last = 1'b1;
    i_channel_rx_length = '0;
    i_channel_rx_offset = '0;
    i_channel_rx_data = '0;
    i_channel_rx_data_valid = 1'b0;
    i_channel_tx_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_rx_ack", 64'(o_channel_rx_ack), 64'(0));
    check("rst_rx_ren", 64'(o_channel_rx_data_ren), 64'(0));
    check("rst_tx", 64'(o_channel_tx), 64'(0));
    check("rst_tx_valid", 64'(o_channel_tx_data_valid), 64'(0));
    check("rst_proc_valid", 64'(o_proc_valid), 64'(0));
    check("rst_status", 64'({o_frame_count, o_overflow, o_truncated}), 64'(0));
    @(negedge clk);
    i_reset_n = 1'b1;

    send_frame(32, 1'b1, 16, 0, 64'h1122_3344_5566_7700, st);
    send_frame(3, 1'b1, 2, 0, 64'hA5A5_0000_0000_0001, st);
    send_frame(0, 1'b1, 0, 0, 64'h0, st);
    check("truncated_clear_before", 64'(o_truncated), 64'(0));
    send_frame(20, 1'b1, 5, 1, 64'hDEAD_BEEF_0000_0010, st);
    check("truncated_set", 64'(o_truncated), 64'(1));

    hold = 200;
    send_frame(2048, 1'b0, 1024, 0, 64'h0F0F_0000_1234_0000, st);
    check("rx_throttled", 64'(st > 0), 64'(1));
    check("no_overflow_kernel", 64'(o_overflow), 64'(0));

    toggle = 1'b1;
    send_frame(10, 1'b0, 5, 0, 64'h7777_8888_9999_AAAA, st);
    toggle = 1'b0;

    send_frame(32, 1'b1, 6, 2, 64'hC0DE_0000_0000_0100, st);
    #1;
    i_reset_n = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    i_channel_rx = 1'b0;
    #1;
    check("arst_rx_ack_ren", 64'({o_channel_rx_ack, o_channel_rx_data_ren}), 64'(0));
    check("arst_tx", 64'({o_channel_tx, o_channel_tx_data_valid}), 64'(0));
    check("arst_tx_data", o_channel_tx_data, 64'(0));
    check("arst_proc_busy", 64'({o_proc_valid, o_busy}), 64'(0));
    check("arst_status", 64'({o_frame_count, o_overflow, o_truncated}), 64'(0));
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(32, 1'b1, 16, 0, 64'h5555_6666_0000_0001, st);
    check("final_overflow", 64'(o_overflow), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit_frame_stream.md
CONTROL_UNIT_FRAME_STREAM -- requirements
Module: control_unit_frame_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 64, RIFFA channel data width in bits; a multiple of 32.
REQ-002 Parameter FIFO_DEPTH, default 512, output buffer depth in beats; a power of two.
REQ-003 Parameter PROC_LATENCY, default 8, worst-case kernel latency in beats, used for the flow-control margin.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk  in  1  single clock; also driven out on o_channel_rx_clk and o_channel_tx_clk.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_bypass  in  1  mode select, sampled at frame start: 1 = rx data goes straight to the FIFO; 0 = rx data goes through the kernel.
- RIFFA RX inputs: i_channel_rx, i_channel_rx_last, i_channel_rx_length[31:0], i_channel_rx_offset[30:0], i_channel_rx_data[DATA_WIDTH], i_channel_rx_data_valid.
- RIFFA RX outputs: o_channel_rx_clk, o_channel_rx_ack, o_channel_rx_data_ren.
- RIFFA TX inputs: i_channel_tx_ack, i_channel_tx_data_ren.
- RIFFA TX outputs: o_channel_tx_clk, o_channel_tx, o_channel_tx_last, o_channel_tx_length[31:0], o_channel_tx_offset[30:0], o_channel_tx_data[DATA_WIDTH], o_channel_tx_data_valid.
- Kernel port: o_proc_data[DATA_WIDTH], o_proc_valid, i_proc_data[DATA_WIDTH], i_proc_valid.
- Status: o_frame_count[15:0], o_overflow (sticky), o_truncated (sticky), o_busy.

Function
REQ-005 State machine is one-hot with states IDLE, ACK, STREAM, DRAIN, PAD.
REQ-006 IDLE -> ACK when i_channel_rx=1; on that edge latch rx_length and i_bypass, compute beats = ceil(rx_length*32/DATA_WIDTH), clear both beat counters.
REQ-007 o_channel_rx_ack SHALL be 1 for exactly one cycle, in ACK; ACK -> IDLE if the latched length is 0 (no TX, frame counted), otherwise ACK -> STREAM.
REQ-008 In STREAM and DRAIN:
- o_channel_tx=1, o_channel_tx_last=1, o_channel_tx_offset=0.
- o_channel_tx_length = latched rx_length, held constant until return to IDLE.
REQ-009 o_channel_rx_data_ren=1 in STREAM only while rx_beats < beats and FIFO usedw < FIFO_DEPTH-PROC_LATENCY-2.
REQ-010 An rx beat is accepted when ren & i_channel_rx_data_valid; it increments rx_beats.
REQ-011 Bypass: an accepted beat is written into the FIFO on the next cycle (one register stage).
REQ-012 Kernel mode: an accepted beat drives o_proc_valid/o_proc_data on the next cycle; every i_proc_valid writes i_proc_data into the FIFO.
REQ-013 o_channel_tx_data_valid = FIFO not empty in STREAM/DRAIN, or 1 in PAD; o_channel_tx_data = FIFO head (zeros in PAD).
REQ-014 A beat is sent when valid & i_channel_tx_data_ren; it pops the FIFO and increments tx_beats.
REQ-015 STREAM -> DRAIN when rx_beats reaches beats.
REQ-016 STREAM -> PAD when i_channel_rx falls before rx_beats reaches beats, once the FIFO is empty and no kernel beat is pending; o_truncated is set.
REQ-017 PAD sends zero beats until tx_beats reaches beats.
REQ-018 DRAIN/PAD -> IDLE when tx_beats reaches beats and the final beat is accepted; o_frame_count increments (wraps at 16 bits).
REQ-019 Simultaneous FIFO push and pop in one cycle SHALL leave usedw unchanged and both operations valid, including at full and at empty.
REQ-020 A FIFO write while full is dropped and sets o_overflow; a pop while empty cannot occur.
REQ-021 Kernel beats that arrive after tx_beats reaches beats are discarded.
REQ-022 o_busy = not IDLE.
REQ-023 A new i_channel_rx while not in IDLE is ignored until the return to IDLE.

Reset
REQ-024 i_reset_n=0 SHALL, asynchronously:
- force IDLE and clear the FIFO and all counters;
- clear o_overflow, o_truncated and o_frame_count;
- drive every channel/kernel valid, ack, ren and tx output to 0.
REQ-025 Reset mid-frame abandons the frame with no further TX beats; after release the block accepts a new frame normally.

Structure
REQ-026 Package frame_stream_pkg holds the state-bit enum, the one-hot state enum and the default parameter constants.
REQ-027 Sub-module sync_fifo_fwft (parametrised DATA_WIDTH/FIFO_DEPTH, synchronous clear, usedw output) provides the buffer; no vendor IP.

Verification
REQ-028 Bypass, rx_length=32, DATA_WIDTH=64 -> exactly 16 TX beats identical to input, tx_length=32, frame_count=1.
REQ-029 Kernel mode with an 8-cycle inverting model, rx_length=2048 words, FIFO_DEPTH=64, tx_data_ren held low for 200 cycles -> rx_ren throttles, o_overflow=0, output is the inverted input in order.
REQ-030 rx_length=3, DATA_WIDTH=64 -> 2 RX and 2 TX beats, tx_length=3.
REQ-031 i_channel_rx dropped after 5 of 10 beats -> 5 data beats then 5 zero beats, o_truncated=1.
REQ-032 rx_length=0 -> one-cycle ack, no o_channel_tx, frame_count increments.
REQ-033 i_reset_n pulsed low mid-STREAM -> all outputs 0 within the same cycle; the next 16-beat frame completes correctly.
